id_ex_stage: RTL and testbench

//  ID->EX pipeline register for the RV32I core. Captures the main-decoder control bundle plus

---
 rtl/rv_ctrl_pkg.sv | 37 +++
 rtl/id_ex_stage_load_use_detector.sv | 18 +
 rtl/id_ex_stage.sv | 157 +++++++++++++++
 tb/tb_id_ex_stage.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: RV32I main-decoder control bundle, bubble constant and field encodings
// Shared by the ID/EX register and the hazard/forwarding logic.
package rv_ctrl_pkg;
  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_JAL  = 2'b01;
  localparam logic [1:0] JUMP_JALR = 2'b10;
  localparam logic [1:0] RES_ALU   = 2'b00;
  localparam logic [1:0] RES_MEM   = 2'b01;
  localparam logic [1:0] RES_PC4   = 2'b10;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  typedef struct packed {
    logic       branch;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [1:0] jump;
  } ctrl_t;
  // No architectural side effects: no write-back, no memory access, no control transfer.
  localparam ctrl_t CTRL_BUBBLE = '{
    branch: 1'b0, mem_write: 1'b0, mem_read: 1'b0, alu_src: 1'b0, reg_write: 1'b0,
    alu_op: ALU_ADD, result_src: RES_ALU, jump: JUMP_NONE
  };
endpackage

// File: rtl/id_ex_stage_load_use_detector.sv
// load_use_detector: flags a decode instruction that reads the destination of a load in EX
// Ports: ex_valid_i/ex_mem_read_i/ex_rd_i describe EX; id_valid_i/id_rs1_i/id_rs2_i describe
// decode; lu_o is the combinational hazard flag.
module load_use_detector #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  output logic              lu_o
);
  // rs2 is compared even for formats that do not read it: a spurious bubble is harmless.
  assign lu_o = ex_valid_i & ex_mem_read_i & (ex_rd_i != '0) & id_valid_i &
                ((id_rs1_i == ex_rd_i) | (id_rs2_i == ex_rd_i));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with load-use bubble, redirect squash and hold
// Ports: clk, rst_n (sync, active low); id_*_i decode bundle, id_ready_o back-pressure to IF/ID;
// ex_redirect_i squash request, mem_hold_i downstream freeze; ex_*_o registered bundle.
// Optional macro ID_EX_PERF_CNT_EN adds perf_stall_cnt_o / perf_flush_cnt_o.
module id_ex_stage
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  output logic              id_ready_o,
  input  logic              id_branch_i,
  input  logic              id_mem_write_i,
  input  logic              id_mem_read_i,
  input  logic              id_alu_src_i,
  input  logic              id_reg_write_i,
  input  logic [1:0]        id_alu_op_i,
  input  logic [1:0]        id_result_src_i,
  input  logic [1:0]        id_jump_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [XLEN-1:0]   id_pc_plus4_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_ext_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [2:0]        id_funct3_i,
  input  logic              id_funct7b5_i,
  input  logic              ex_redirect_i,
  input  logic              mem_hold_i,
  output logic              ex_valid_o,
  output logic              ex_branch_o,
  output logic              ex_mem_write_o,
  output logic              ex_mem_read_o,
  output logic              ex_alu_src_o,
  output logic              ex_reg_write_o,
  output logic [1:0]        ex_alu_op_o,
  output logic [1:0]        ex_result_src_o,
  output logic [1:0]        ex_jump_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_pc_plus4_o,
  output logic [XLEN-1:0]   ex_rs1_data_o,
  output logic [XLEN-1:0]   ex_rs2_data_o,
  output logic [XLEN-1:0]   ex_imm_ext_o,
  output logic [REG_AW-1:0] ex_rs1_o,
  output logic [REG_AW-1:0] ex_rs2_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [2:0]        ex_funct3_o,
  output logic              ex_funct7b5_o
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt_o,
  output logic [31:0]       perf_flush_cnt_o
`endif
);
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm_ext;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic              funct7b5;
  } dp_t;
  ctrl_t id_ctrl, ctrl_d, ctrl_q;
  dp_t   id_dp, dp_d, dp_q;
  logic  valid_d, valid_q;
  logic  pend_d, pend_q;
  logic  lu, flush, stall, bubble;
  load_use_detector #(.REG_AW(REG_AW)) u_lu (
    .ex_valid_i   (valid_q),
    .ex_mem_read_i(ctrl_q.mem_read),
    .ex_rd_i      (dp_q.rd),
    .id_valid_i   (id_valid_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .lu_o         (lu)
  );
  always_comb begin
    id_ctrl = '{
      branch: id_branch_i, mem_write: id_mem_write_i, mem_read: id_mem_read_i,
      alu_src: id_alu_src_i, reg_write: id_reg_write_i, alu_op: id_alu_op_i,
      result_src: id_result_src_i, jump: id_jump_i
    };
    id_dp = '{
      pc: id_pc_i, pc_plus4: id_pc_plus4_i, rs1_data: id_rs1_data_i, rs2_data: id_rs2_data_i,
      imm_ext: id_imm_ext_i, rs1: id_rs1_i, rs2: id_rs2_i, rd: id_rd_i,
      funct3: id_funct3_i, funct7b5: id_funct7b5_i
    };
    // A redirect seen during a hold is remembered and applied on the first free edge.
    flush   = !mem_hold_i & (ex_redirect_i | pend_q);
    stall   = !mem_hold_i & !flush & lu;
    bubble  = flush | stall;
    pend_d  = mem_hold_i & (pend_q | ex_redirect_i);
    valid_d = mem_hold_i ? valid_q : !bubble & id_valid_i;
    ctrl_d  = mem_hold_i ? ctrl_q : (bubble | !id_valid_i) ? CTRL_BUBBLE : id_ctrl;
    dp_d    = mem_hold_i ? dp_q : bubble ? '0 : id_dp;
    // On a flush the IF/ID slot is discarded upstream, so ready stays high.
    id_ready_o = !rst_n | (!mem_hold_i & !stall);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      ctrl_q  <= CTRL_BUBBLE;
      dp_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pend_q  <= pend_d;
      ctrl_q  <= ctrl_d;
      dp_q    <= dp_d;
    end
  end
  assign ex_valid_o      = valid_q;
  assign ex_branch_o     = ctrl_q.branch;
  assign ex_mem_write_o  = ctrl_q.mem_write;
  assign ex_mem_read_o   = ctrl_q.mem_read;
  assign ex_alu_src_o    = ctrl_q.alu_src;
  assign ex_reg_write_o  = ctrl_q.reg_write;
  assign ex_alu_op_o     = ctrl_q.alu_op;
  assign ex_result_src_o = ctrl_q.result_src;
  assign ex_jump_o       = ctrl_q.jump;
  assign ex_pc_o         = dp_q.pc;
  assign ex_pc_plus4_o   = dp_q.pc_plus4;
  assign ex_rs1_data_o   = dp_q.rs1_data;
  assign ex_rs2_data_o   = dp_q.rs2_data;
  assign ex_imm_ext_o    = dp_q.imm_ext;
  assign ex_rs1_o        = dp_q.rs1;
  assign ex_rs2_o        = dp_q.rs2;
  assign ex_rd_o         = dp_q.rd;
  assign ex_funct3_o     = dp_q.funct3;
  assign ex_funct7b5_o   = dp_q.funct7b5;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;
  // stall/flush are already gated by mem_hold, so counters freeze while held.
  assign stall_cnt_d = stall_cnt_q + 32'(stall);
  assign flush_cnt_d = flush_cnt_q + 32'(flush);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
  typedef struct packed {
    logic        branch, mem_write, mem_read, alu_src, reg_write;
    logic [1:0]  alu_op, result_src, jump;
    logic [31:0] pc, pc4, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
  } bun_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0, id_valid = 1'b0, ex_redirect = 1'b0, mem_hold = 1'b0;
  bun_t idb = '0;
  logic id_ready, ex_valid;
  logic ex_branch, ex_mem_write, ex_mem_read, ex_alu_src, ex_reg_write, ex_f7;
  logic [1:0] ex_alu_op, ex_result_src, ex_jump;
  logic [31:0] ex_pc, ex_pc4, ex_rs1d, ex_rs2d, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_f3;
  bun_t exb;
  int checks = 0, errors = 0;
  bun_t m_ex = '0;
  logic m_valid = 1'b0, m_pend = 1'b0;
  logic [31:0] m_stall = '0, m_flush = '0;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_stall, perf_flush;
`endif
  assign exb = {ex_branch, ex_mem_write, ex_mem_read, ex_alu_src, ex_reg_write, ex_alu_op,
                ex_result_src, ex_jump, ex_pc, ex_pc4, ex_rs1d, ex_rs2d, ex_imm,
                ex_rs1, ex_rs2, ex_rd, ex_f3, ex_f7};
  always #5 clk = ~clk;
  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_ready_o(id_ready),
    .id_branch_i(idb.branch), .id_mem_write_i(idb.mem_write), .id_mem_read_i(idb.mem_read),
    .id_alu_src_i(idb.alu_src), .id_reg_write_i(idb.reg_write), .id_alu_op_i(idb.alu_op),
    .id_result_src_i(idb.result_src), .id_jump_i(idb.jump), .id_pc_i(idb.pc),
    .id_pc_plus4_i(idb.pc4), .id_rs1_data_i(idb.rs1d), .id_rs2_data_i(idb.rs2d),
    .id_imm_ext_i(idb.imm), .id_rs1_i(idb.rs1), .id_rs2_i(idb.rs2), .id_rd_i(idb.rd),
    .id_funct3_i(idb.f3), .id_funct7b5_i(idb.f7), .ex_redirect_i(ex_redirect),
    .mem_hold_i(mem_hold), .ex_valid_o(ex_valid), .ex_branch_o(ex_branch),
    .ex_mem_write_o(ex_mem_write), .ex_mem_read_o(ex_mem_read), .ex_alu_src_o(ex_alu_src),
    .ex_reg_write_o(ex_reg_write), .ex_alu_op_o(ex_alu_op), .ex_result_src_o(ex_result_src),
    .ex_jump_o(ex_jump), .ex_pc_o(ex_pc), .ex_pc_plus4_o(ex_pc4), .ex_rs1_data_o(ex_rs1d),
    .ex_rs2_data_o(ex_rs2d), .ex_imm_ext_o(ex_imm), .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2),
    .ex_rd_o(ex_rd), .ex_funct3_o(ex_f3), .ex_funct7b5_o(ex_f7)
`ifdef ID_EX_PERF_CNT_EN
    , .perf_stall_cnt_o(perf_stall), .perf_flush_cnt_o(perf_flush)
`endif
  );
  function automatic bun_t rand_bun();
    bun_t b;
    b.branch = 1'($urandom); b.mem_write = 1'($urandom); b.mem_read = 1'($urandom);
    b.alu_src = 1'($urandom); b.reg_write = 1'($urandom); b.alu_op = 2'($urandom);
    b.result_src = 2'($urandom); b.jump = 2'($urandom);
    b.pc = $urandom; b.pc4 = $urandom; b.rs1d = $urandom; b.rs2d = $urandom; b.imm = $urandom;
    b.rs1 = 5'($urandom); b.rs2 = 5'($urandom); b.rd = 5'($urandom);
    b.f3 = 3'($urandom); b.f7 = 1'($urandom);
    return b;
  endfunction
  function automatic bun_t rtype(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    bun_t b = rand_bun();
    {b.branch, b.mem_write, b.mem_read, b.alu_src, b.reg_write} = 5'b00001;
    b.alu_op = 2'b10; b.result_src = 2'b00; b.jump = 2'b00;
    b.pc4 = b.pc + 32'd4; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.f3 = 3'b000; b.f7 = 1'b0;
    return b;
  endfunction
  function automatic bun_t lw(logic [4:0] rd, logic [4:0] rs1);
    bun_t b = rand_bun();
    {b.branch, b.mem_write, b.mem_read, b.alu_src, b.reg_write} = 5'b00111;
    b.alu_op = 2'b00; b.result_src = 2'b01; b.jump = 2'b00;
    b.pc4 = b.pc + 32'd4; b.rd = rd; b.rs1 = rs1; b.rs2 = 5'd0; b.imm = 32'd0; b.f3 = 3'b010;
    return b;
  endfunction
  function automatic bun_t kill_ctrl(bun_t b);
    bun_t r = b;
    r.branch = 1'b0; r.mem_write = 1'b0; r.mem_read = 1'b0; r.reg_write = 1'b0; r.jump = 2'b00;
    return r;
  endfunction
  function automatic logic m_lu();
    return m_valid && m_ex.mem_read && m_ex.rd != 5'd0 && id_valid &&
           (idb.rs1 == m_ex.rd || idb.rs2 == m_ex.rd);
  endfunction
  function automatic logic m_ready();
    if (!rst_n) return 1'b1;
    if (mem_hold) return 1'b0;
    if (ex_redirect || m_pend) return 1'b1;
    return !m_lu();
  endfunction
  task automatic tick();
    logic lu;
    lu = m_lu();
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_ex = '0; m_pend = 1'b0; m_stall = '0; m_flush = '0;
    end else if (mem_hold) begin
      if (ex_redirect) m_pend = 1'b1;
    end else if (ex_redirect || m_pend) begin
      m_valid = 1'b0; m_ex = kill_ctrl(m_ex); m_pend = 1'b0; m_flush = m_flush + 32'd1;
    end else if (lu) begin
      m_valid = 1'b0; m_ex = kill_ctrl(m_ex); m_stall = m_stall + 32'd1;
    end else begin
      m_valid = id_valid; m_ex = id_valid ? idb : kill_ctrl(idb);
    end
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0; mem_hold = 1'b0; ex_redirect = 1'b0; id_valid = 1'b1; idb = rand_bun();
    tick(); tick();
    rst_n = 1'b1; id_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; mem_hold = 1'b0; ex_redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      id_valid = 1'b1; idb = rand_bun(); #1;
      checks++;
      if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", id_ready); end
      tick();
      checks++;
      if ({ex_valid, ex_reg_write, ex_jump} !== 4'b0000) begin
        errors++; $display("FAIL reset_state valid=%0b rw=%0b jump=%0b exp=0,0,00", ex_valid, ex_reg_write, ex_jump);
      end
    end
`ifdef ID_EX_PERF_CNT_EN
    checks++;
    if ({perf_stall, perf_flush} !== 64'd0) begin
      errors++; $display("FAIL reset_cnt stall=%0d flush=%0d exp=0,0", perf_stall, perf_flush);
    end
`endif
    rst_n = 1'b1; id_valid = 1'b0;
  endtask
  task automatic test_pass_through();
    bun_t add;
    do_reset();
    add = rtype(5'd3, 5'd1, 5'd2);
    idb = add; id_valid = 1'b1; #1;
    checks++;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL pass_ready got=%0b exp=1", id_ready); end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || exb !== add) begin
      errors++; $display("FAIL pass_bundle valid=%0b got=%h exp=%h", ex_valid, exb, add);
    end
    id_valid = 1'b0; tick();
    checks++;
    if (ex_valid !== 1'b0 || {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump} !== 6'd0) begin
      errors++; $display("FAIL idle_bubble valid=%0b rw=%0b exp=0,0", ex_valid, ex_reg_write);
    end
  endtask
  task automatic test_load_use();
    bun_t add;
    do_reset();
    idb = lw(5'd5, 5'd1); id_valid = 1'b1; tick();
    add = rtype(5'd6, 5'd5, 5'd7);
    idb = add; #1;
    checks++;
    if (id_ready !== 1'b0) begin errors++; $display("FAIL lu_ready got=%0b exp=0", id_ready); end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0) begin
      errors++; $display("FAIL lu_bubble valid=%0b mr=%0b rw=%0b exp=0,0,0", ex_valid, ex_mem_read, ex_reg_write);
    end
    checks++;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_once ready=%0b exp=1", id_ready); end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || exb !== add) begin
      errors++; $display("FAIL lu_add valid=%0b got=%h exp=%h", ex_valid, exb, add);
    end
`ifdef ID_EX_PERF_CNT_EN
    checks++;
    if (perf_stall !== 32'd1) begin errors++; $display("FAIL lu_cnt got=%0d exp=1", perf_stall); end
`endif
    id_valid = 1'b0;
  endtask
  task automatic test_x0();
    do_reset();
    idb = lw(5'd0, 5'd1); id_valid = 1'b1; tick();
    idb = rtype(5'd6, 5'd0, 5'd0); #1;
    checks++;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got=%0b exp=1", id_ready); end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd6) begin
      errors++; $display("FAIL x0_pass valid=%0b rd=%0d exp=1,6", ex_valid, ex_rd);
    end
    id_valid = 1'b0;
  endtask
  task automatic test_redirect_lu();
    do_reset();
    idb = lw(5'd5, 5'd1); id_valid = 1'b1; tick();
    idb = rtype(5'd6, 5'd5, 5'd7); ex_redirect = 1'b1; #1;
    checks++;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL redir_ready got=%0b exp=1", id_ready); end
    tick();
    ex_redirect = 1'b0; id_valid = 1'b0;
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin
      errors++; $display("FAIL redir_bubble valid=%0b rw=%0b mr=%0b exp=0,0,0", ex_valid, ex_reg_write, ex_mem_read);
    end
`ifdef ID_EX_PERF_CNT_EN
    checks++;
    if (perf_flush !== 32'd1 || perf_stall !== 32'd0) begin
      errors++; $display("FAIL redir_cnt flush=%0d stall=%0d exp=1,0", perf_flush, perf_stall);
    end
`endif
  endtask
  task automatic test_hold_redirect();
    bun_t add, snap;
    do_reset();
    add = rtype(5'd3, 5'd1, 5'd2); idb = add; id_valid = 1'b1; tick();
    snap = exb;
    for (int i = 0; i < 3; i++) begin
      mem_hold = 1'b1; ex_redirect = (i == 0); idb = rand_bun(); #1;
      checks++;
      if (id_ready !== 1'b0) begin errors++; $display("FAIL hold_ready cyc=%0d got=%0b exp=0", i, id_ready); end
      tick();
      checks++;
      if (ex_valid !== 1'b1 || exb !== add || exb !== snap) begin
        errors++; $display("FAIL hold_frozen cyc=%0d got=%h exp=%h", i, exb, add);
      end
    end
    mem_hold = 1'b0; ex_redirect = 1'b0; idb = rtype(5'd9, 5'd4, 5'd4); #1;
    checks++;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready got=%0b exp=1", id_ready); end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
      errors++; $display("FAIL hold_pending_bubble valid=%0b rw=%0b exp=0,0", ex_valid, ex_reg_write);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd9) begin
      errors++; $display("FAIL hold_resume valid=%0b rd=%0d exp=1,9", ex_valid, ex_rd);
    end
    id_valid = 1'b0;
  endtask
  task automatic test_back_to_back();
    bun_t q[$];
    int idx = 0, stalls = 0;
    do_reset();
    q.push_back(lw(5'd5, 5'd1));
    q.push_back(lw(5'd6, 5'd2));
    q.push_back(rtype(5'd7, 5'd6, 5'd8));
    for (int c = 0; c < 10 && idx < 3; c++) begin
      idb = q[idx]; id_valid = 1'b1; #1;
      if (id_ready) idx++; else stalls++;
      tick();
    end
    id_valid = 1'b0;
    checks++;
    if (idx != 3 || stalls != 1) begin
      errors++; $display("FAIL b2b_stalls issued=%0d stalls=%0d exp=3,1", idx, stalls);
    end
    checks++;
    if (ex_valid !== 1'b1 || exb !== q[2]) begin
      errors++; $display("FAIL b2b_third valid=%0b got=%h exp=%h", ex_valid, exb, q[2]);
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      mem_hold = ($urandom_range(0, 5) == 0);
      ex_redirect = ($urandom_range(0, 7) == 0);
      id_valid = ($urandom_range(0, 4) != 0);
      idb = rand_bun();
      idb.rd = 5'($urandom_range(0, 3)); idb.rs1 = 5'($urandom_range(0, 3));
      idb.rs2 = 5'($urandom_range(0, 3)); idb.mem_read = ($urandom_range(0, 2) == 0);
      #1;
      checks++;
      if (id_ready !== m_ready()) begin
        errors++; $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, id_ready, m_ready());
      end
      tick();
      checks++;
      if (ex_valid !== m_valid) begin
        errors++; $display("FAIL rnd_valid n=%0d got=%0b exp=%0b", n, ex_valid, m_valid);
      end else if (m_valid && exb !== m_ex) begin
        errors++; $display("FAIL rnd_bundle n=%0d got=%h exp=%h", n, exb, m_ex);
      end else if (!m_valid && {ex_branch, ex_mem_write, ex_mem_read, ex_reg_write, ex_jump} !== 6'd0) begin
        errors++; $display("FAIL rnd_bubble_ctrl n=%0d got=%b exp=0", n, {ex_branch, ex_mem_write, ex_mem_read, ex_reg_write, ex_jump});
      end
`ifdef ID_EX_PERF_CNT_EN
      checks++;
      if (perf_stall !== m_stall || perf_flush !== m_flush) begin
        errors++; $display("FAIL rnd_cnt n=%0d got=%0d,%0d exp=%0d,%0d", n, perf_stall, perf_flush, m_stall, m_flush);
      end
`endif
    end
    rst_n = 1'b1; mem_hold = 1'b0; ex_redirect = 1'b0; id_valid = 1'b0;
  endtask
  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_x0();
    test_redirect_lu();
    test_hold_redirect();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
